// File: rtl/ddr3_write_buffer.sv
// rtl/ddr3_write_buffer.sv - posted-write FIFO between the system bus and ddr3_dev
// Define WBUF_FORWARD_EN to serve reads that hit queued writes straight from the buffer.
module ddr3_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  input  logic          we_i,
  input  logic          rd_i,
  output logic          ack_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          mem_we_o,
  output logic          mem_rd_o,
  input  logic          mem_ack_i,
  output logic          empty_o,
  output logic          full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t        state;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          wr_req;
  logic          rd_req;
  logic          enq;
  logic          pop;
  logic          rd_go;
  logic          fwd_hit;
  logic [DW-1:0] hit_data;

  // The ack cycle belongs to the finished request, so nothing is evaluated then.
  assign wr_req = we_i && !ack_o;
  assign rd_req = rd_i && !we_i && !ack_o;
  assign enq    = wr_req && (count < DEPTH_C);
  assign pop    = (state == WR) && mem_ack_i;

`ifdef WBUF_FORWARD_EN
  logic hit;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (fifo_addr[idx][AW-1:2] == addr_i[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = fifo_data[idx];
      end
    end
  end

  assign fwd_hit = rd_req && hit && ((state == IDLE) || (state == WR));
  assign rd_go   = rd_req && !hit && (state == IDLE);
`else
  assign hit_data = '0;
  assign fwd_hit  = 1'b0;
  assign rd_go    = rd_req && (state == IDLE) && (count == '0);
`endif

  always_comb begin
    count_next = count;
    if (enq && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !enq) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= addr_i;
      fifo_data[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ack_o      <= 1'b0;
      data_o     <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_we_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
      full_o     <= 1'b0;
      empty_o    <= 1'b1;
    end else begin
      ack_o <= 1'b0;
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        ack_o  <= 1'b1;
      end
      if (fwd_hit) begin
        data_o <= hit_data;
        ack_o  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rd_go) begin
            state      <= RD;
            mem_rd_o   <= 1'b1;
            mem_addr_o <= addr_i;
          end else if (count != '0) begin
            state      <= WR;
            mem_we_o   <= 1'b1;
            mem_addr_o <= fifo_addr[rd_ptr];
            mem_data_o <= fifo_data[rd_ptr];
          end
        end
        WR: begin
          if (mem_ack_i) begin
            mem_we_o <= 1'b0;
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= IDLE;
          end
        end
        RD: begin
          if (mem_ack_i) begin
            mem_rd_o <= 1'b0;
            data_o   <= mem_data_i;
            ack_o    <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      count   <= count_next;
      full_o  <= (count_next == DEPTH_C);
      empty_o <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_ddr3_write_buffer.sv
// tb/tb_ddr3_write_buffer.sv - directed bench for ddr3_write_buffer with a bus-level memory model
module tb_ddr3_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i, data_i, data_o, mem_addr_o, mem_data_o, mem_data_i;
  logic        we_i, rd_i, ack_o, mem_we_o, mem_rd_o, mem_ack_i, empty_o, full_o;

  ddr3_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_we_o(mem_we_o),
    .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: accepted-but-undrained writes, bus-visible memory, and the downstream log.
  logic [63:0] pend_q[$];
  logic [64:0] log_q[$];
  logic [31:0] shadow[int];
  logic [31:0] memory[int];
  int          cnt;
  bit          started, exp_ack, rd_active, rd_act_s;
  bit          pop_chk, pop_ok, wr_hold, rd_hold;
  logic [63:0] pop_act, pop_exp;
  logic [31:0] held_a, held_d, held_ra;
  bit          hold;
  int          ack_delay, wcnt;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h300) ? 32'h12345678 : (32'h0BAD0000 | a);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    int w = int'(a >> 2);
    if (memory.exists(w)) return memory[w];
    return init_word(a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int w = int'(a >> 2);
    if (shadow.exists(w)) return shadow[w];
    return init_word(a);
  endfunction

  task automatic tick();
    bit enq, pop;
    @(posedge clk);
    pop_chk = 0;
    if (rst) begin
      cnt = 0; pend_q.delete(); exp_ack = 0; wr_hold = 0; rd_hold = 0;
      rd_act_s = 0; started = 1;
    end else begin
      enq = we_i && !ack_o && (cnt < DEPTH);
      pop = mem_we_o && mem_ack_i;
      exp_ack = enq;
      rd_act_s = rd_active;
      if (pop) begin
        pop_chk = 1;
        pop_ok = (pend_q.size() > 0);
        pop_act = {mem_addr_o, mem_data_o};
        if (pop_ok) pop_exp = pend_q.pop_front();
        else pop_exp = '0;
        memory[int'(mem_addr_o >> 2)] = mem_data_o;
        log_q.push_back({1'b0, mem_addr_o, mem_data_o});
      end
      if (mem_rd_o && mem_ack_i) log_q.push_back({1'b1, mem_addr_o, mem_data_i});
      if (enq) begin
        pend_q.push_back({addr_i, data_i});
        shadow[int'(addr_i >> 2)] = data_i;
      end
      cnt = cnt + int'(enq) - int'(pop);
      wr_hold = mem_we_o && !mem_ack_i;
      held_a = mem_addr_o; held_d = mem_data_o;
      rd_hold = mem_rd_o && !mem_ack_i;
      held_ra = mem_addr_o;
    end
    @(negedge clk);
    if (started) begin
      chk("empty_o", empty_o, cnt == 0);
      chk("full_o", full_o, cnt == DEPTH);
      if (!rd_act_s) chk("wr_ack", ack_o, exp_ack);
      chk("we_rd_excl", mem_we_o & mem_rd_o, 0);
      if (pop_chk) begin
        chk("pop_nonempty", pop_ok, 1);
        chk("drain_order", pop_act, pop_exp);
      end
      if (wr_hold) begin
        chk("wr_hold_we", mem_we_o, 1);
        chk("wr_hold_addr", mem_addr_o, held_a);
        chk("wr_hold_data", mem_data_o, held_d);
      end
      if (rd_hold) begin
        chk("rd_hold_rd", mem_rd_o, 1);
        chk("rd_hold_addr", mem_addr_o, held_ra);
      end
`ifndef WBUF_FORWARD_EN
      if (mem_rd_o) chk("rd_before_drain", cnt, 0);
`endif
    end
    // Memory responder
    if (mem_ack_i) begin
      mem_ack_i = 0; wcnt = 0;
    end else if (hold) begin
      wcnt = 0;
    end else if (mem_we_o || mem_rd_o) begin
      wcnt++;
      if (wcnt >= ack_delay) begin
        mem_ack_i = 1;
        if (mem_rd_o) mem_data_i = mem_read(mem_addr_o);
      end
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int release_at,
                           output int lat);
    bit got = 0;
    we_i = 1; addr_i = a; data_i = d; lat = 0;
    if (ack_o) tick();
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      lat++;
      if (ack_o) got = 1;
      else if (lat == release_at) hold = 0;
    end
    chk("wr_ack_seen", got, 1);
    we_i = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, input int release_at,
                          output logic [31:0] d, output int lat, output bit rd_seen);
    bit got = 0;
    rd_active = 1; rd_i = 1; addr_i = a; lat = 0; rd_seen = 0; d = '0;
    if (ack_o) tick();
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      lat++;
      if (mem_rd_o) rd_seen = 1;
      if (ack_o) begin
        got = 1; d = data_o;
      end else if (lat == release_at) hold = 0;
    end
    chk("rd_ack_seen", got, 1);
    rd_i = 0; rd_active = 0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && !empty_o; i++) tick();
    chk(name, empty_o, 1);
  endtask

  task automatic wait_we();
    for (int i = 0; i < 20 && !mem_we_o; i++) tick();
    chk("mem_we_seen", mem_we_o, 1);
  endtask

  task automatic chk_log(input int base, input int idx, input logic [64:0] e);
    logic [64:0] a = '1;
    if (base + idx < log_q.size()) a = log_q[base + idx];
    chk($sformatf("log_%0d", idx), a, e);
  endtask

  initial begin
    int lat, base;
    bit seen;
    logic [31:0] d;
    rst = 1; we_i = 0; rd_i = 0; addr_i = '0; data_i = '0;
    mem_data_i = '0; mem_ack_i = 0; hold = 1; ack_delay = 1; wcnt = 0;
    started = 0; rd_active = 0; cnt = 0;
    repeat (3) tick();
    chk("rst_ack", ack_o, 0);       chk("rst_we", mem_we_o, 0);
    chk("rst_rd", mem_rd_o, 0);     chk("rst_full", full_o, 0);
    chk("rst_empty", empty_o, 1);   chk("rst_data", data_o, 0);
    chk("rst_maddr", mem_addr_o, 0); chk("rst_mdata", mem_data_o, 0);
    rst = 0;
    tick();

    // Single post
    hold = 0; ack_delay = 5;
    bus_write(32'h100, 32'hDEADBEEF, 0, lat);
    chk("post_lat", lat, 1);
    wait_we();
    chk("post_addr", mem_addr_o, 32'h100);
    chk("post_data", mem_data_o, 32'hDEADBEEF);
    wait_empty("post_empty");

    // Fill and stall
    hold = 1; ack_delay = 1;
    for (int i = 0; i < 4; i++) begin
      bus_write(32'h1000 + 32'(4 * i), 32'hF000 + 32'(i), 0, lat);
      chk($sformatf("fill_lat_%0d", i), lat, 1);
    end
    chk("fill_full", full_o, 1);
    bus_write(32'h1010, 32'hF004, 3, lat);
    chk("stall_lat", lat, 6);
    wait_empty("fill_drain");

    // Ordering
    base = log_q.size();
    hold = 0; ack_delay = 1;
    bus_write(32'h10, 32'h1, 0, lat);
    bus_write(32'h14, 32'h2, 0, lat);
    bus_write(32'h10, 32'h3, 0, lat);
    wait_empty("order_drain");
    chk("order_len", log_q.size() - base, 3);
    chk_log(base, 0, {1'b0, 32'h10, 32'h1});
    chk_log(base, 1, {1'b0, 32'h14, 32'h2});
    chk_log(base, 2, {1'b0, 32'h10, 32'h3});

    // Read after write
    hold = 1; ack_delay = 2;
    bus_write(32'h200, 32'hA5A5A5A5, 0, lat);
`ifdef WBUF_FORWARD_EN
    bus_read(32'h200, 0, d, lat, seen);
    chk("raw_lat", lat, 1);
    chk("raw_no_mem_rd", seen, 0);
    hold = 0;
`else
    bus_read(32'h200, 4, d, lat, seen);
    chk("raw_mem_rd", seen, 1);
`endif
    chk("raw_data", d, 32'hA5A5A5A5);
    chk("raw_model", d, exp_read(32'h200));
    wait_empty("raw_drain");

    // Youngest of two matching entries
    hold = 1; ack_delay = 2;
    bus_write(32'h500, 32'h1, 0, lat);
    bus_write(32'h500, 32'h2, 0, lat);
    bus_read(32'h502, 4, d, lat, seen);
    chk("young_data", d, 32'h2);
    chk("young_model", d, exp_read(32'h500));
    hold = 0;
    wait_empty("young_drain");

    // Read miss with queued writes
    base = log_q.size();
    hold = 1; ack_delay = 2;
    bus_write(32'h400, 32'h11, 0, lat);
    bus_write(32'h404, 32'h22, 0, lat);
    bus_write(32'h408, 32'h33, 0, lat);
    bus_read(32'h300, 3, d, lat, seen);
    chk("miss_data", d, 32'h12345678);
    chk("miss_mem_rd", seen, 1);
    wait_empty("miss_drain");
    chk("miss_len", log_q.size() - base, 4);
    chk_log(base, 0, {1'b0, 32'h400, 32'h11});
`ifdef WBUF_FORWARD_EN
    chk_log(base, 1, {1'b1, 32'h300, 32'h12345678});
    chk_log(base, 2, {1'b0, 32'h404, 32'h22});
    chk_log(base, 3, {1'b0, 32'h408, 32'h33});
`else
    chk_log(base, 1, {1'b0, 32'h404, 32'h22});
    chk_log(base, 2, {1'b0, 32'h408, 32'h33});
    chk_log(base, 3, {1'b1, 32'h300, 32'h12345678});
`endif

    // Reset mid-drain
    hold = 1;
    bus_write(32'h600, 32'h66, 0, lat);
    bus_write(32'h604, 32'h67, 0, lat);
    wait_we();
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_we", mem_we_o, 0);
    chk("mrst_empty", empty_o, 1);
    chk("mrst_full", full_o, 0);
    chk("mrst_ack", ack_o, 0);
    tick();
    hold = 0; ack_delay = 5;
    bus_write(32'h100, 32'hDEADBEEF, 0, lat);
    chk("mrst_post_lat", lat, 1);
    wait_we();
    chk("mrst_post_addr", mem_addr_o, 32'h100);
    chk("mrst_post_data", mem_data_o, 32'hDEADBEEF);
    wait_empty("mrst_post_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
